// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one external adder between two requesters and
// returns each result on a single registered response channel tagged with the requester id.
module adder_arbiter #(
    parameter int OPERAND_LENGTH = 32,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [OPERAND_LENGTH-1:0] req0_opd1,
    input  logic [OPERAND_LENGTH-1:0] req0_opd2,
    input  logic                      req0_sub,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [OPERAND_LENGTH-1:0] req1_opd1,
    input  logic [OPERAND_LENGTH-1:0] req1_opd2,
    input  logic                      req1_sub,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [OPERAND_LENGTH-1:0] rsp_result,
    output logic [OPERAND_LENGTH-1:0] adder_opd1,
    output logic [OPERAND_LENGTH-1:0] adder_opd2,
    output logic [3:0]                adder_op_sel,
    input  logic [OPERAND_LENGTH-1:0] adder_result,
    output logic [COUNT_WIDTH-1:0]    op_count,
    output logic                      dbg_state
);

    // Handshake: a transfer happens on a channel in any cycle where valid && ready
    // are both high at the rising edge; ready never depends on a registered valid,
    // and a source may withdraw valid before ready without leaving any state here.

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   accept;
    logic   grant0, grant1, grant_any;

    always_comb begin
        accept       = 1'b0;
        grant0       = 1'b0;
        grant1       = 1'b0;
        grant_any    = 1'b0;
        state_nxt    = state;
        adder_opd1   = '0;
        adder_opd2   = '0;
        adder_op_sel = 4'b0000;

        // Accept while empty, or while the held response drains this same cycle.
        accept    = rst_n && ((state == IDLE) || rsp_ready);
        grant0    = accept && req0_valid && (!req1_valid || last_grant);
        grant1    = accept && req1_valid && (!req0_valid || !last_grant);
        grant_any = grant0 || grant1;

        if (grant0) begin
            adder_opd1   = req0_opd1;
            adder_opd2   = req0_opd2;
            adder_op_sel = req0_sub ? 4'b1000 : 4'b0000;
        end else if (grant1) begin
            adder_opd1   = req1_opd1;
            adder_opd2   = req1_opd2;
            adder_op_sel = req1_sub ? 4'b1000 : 4'b0000;
        end

        case (state)
            IDLE: if (grant_any) state_nxt = RESP;
            RESP: if (rsp_ready && !grant_any) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == RESP);
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            op_count   <= '0;
        end else begin
            if (grant_any) begin
                rsp_result <= adder_result;
                rsp_id     <= grant1;
                last_grant <= grant1;
            end
            if (rsp_valid && rsp_ready) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule
